axi_lite_nto1_arbiter: RTL and testbench
========================================

# axi_lite_nto1_arbiter

Parametrised N-master to 1-slave AXI4-Lite arbiter between the core's bus masters (IFU, LSU/WBU, DMA-style extras) and the single memory/xbar port. One transaction (read or write) is in flight at a time. Grant is fixed-priority or round-robin. Once granted, channels are passed through combinationally.

## Interface
- `NUM_M`, default 2: number of masters (1..8); master 0 = highest fixed priority.
- `AW`, default 32: address width.
- `DW`, default 32: data width (32 or 64); strobe width = DW/8.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_arvalid`/`m_arready`  in/out  NUM_M  per-master read address handshake.
- `m_araddr`  in  NUM_M*AW  packed, master i at [i*AW +: AW].
- `m_rvalid`/`m_rready`  out/in  NUM_M  per-master read data handshake.
- `m_rdata` out NUM_M*DW; `m_rresp` out NUM_M*2.
- `m_awvalid`/`m_awready`, `m_wvalid`/`m_wready`, `m_bvalid`/`m_bready`  per-master write channels, NUM_M each.
- `m_awaddr` in NUM_M*AW; `m_wdata` in NUM_M*DW; `m_wstrb` in NUM_M*DW/8; `m_bresp` out NUM_M*2.
- `mem_*`  slave-side AR/R/AW/W/B with the same widths as one master.
- `grant`  out  clog2(NUM_M) max 1  index of the current owner.
- `busy`  out  1  high outside IDLE.

## Operation
- States: IDLE, RD, WR, encoded in `arb_pkg`.
- IDLE: req[i] = m_arvalid[i] | m_awvalid[i]. Arbiter picks winner w, latches `grant`<=w, goes to WR if m_awvalid[w], else RD. A master requesting both gets write first.
- Fixed priority: lowest index among req wins.
- RD: mem_arvalid = m_arvalid[g] & ~ar_done. mem_araddr = m_araddr[g]. m_arready[g] = mem_arready. R channel is muxed to/from g. ar_done sets on AR handshake. Exit to IDLE on R handshake (mem_rvalid & m_rready[g]).
- WR: AW and W are independent, tracked by aw_done and w_done. Each is forwarded until its handshake, then masked. B is routed to g. Exit to IDLE on B handshake.
- Non-granted masters see all ready/valid outputs = 0. Their rdata/rresp/bresp are 0.
- A new request arriving in RD/WR waits; it is never dropped.
- Master valid deasserting before its handshake violates AXI. Behaviour is undefined, no recovery.

## Timing
- Reset (async, any state, mid-transaction included): state=IDLE, grant=0, RR pointer=0, done flags=0, busy=0. All `m_*` and `mem_*` outputs = 0.
- Arbitration takes 1 cycle: request in IDLE at cycle t, so mem_arvalid/mem_awvalid is asserted at t+1.
- After the data path is granted, it adds zero latency: passthrough is combinational.
- Completing handshake at cycle t puts state at IDLE in t+1. The earliest next grant is at t+1, so the next slave valid comes at t+2. There is a 1-cycle bubble between transactions.
- AW and W may complete in either order or in the same cycle. B is accepted only after both complete.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin. An RR pointer p is searched from p upward with wrap-around. On the completing handshake p <= grant+1 mod NUM_M.
- Undefined: fixed priority (lowest index). No pointer register.
- Write-over-read within one master applies in both modes.

## Structure
- `arb_pkg`: state enum {IDLE, RD, WR}, AXI resp constants (OKAY=2'b00, SLVERR=2'b10), a clog2 helper for the grant width.
- Sub-module `arb_rr_pick`: a combinational NUM_M-wide picker taking req, pointer and mode, returning a one-hot winner and its index. In fixed mode it is fed pointer=0.
- Top contains the FSM, done flags and channel muxes.

## Test plan
- Single read: NUM_M=2, m_arvalid[1], addr 0x8000_0010. Slave returns 0xDEADBEEF after 3 cycles. Required: mem_araddr=0x8000_0010 at t+1, m_rdata[1]=0xDEADBEEF, m_rvalid[0] never high, busy low the cycle after the R handshake.
- Write ordering: slave accepts W two cycles before AW, then returns bresp=OKAY. Required: mem_wvalid drops after its handshake, m_bvalid[0] rises exactly with mem_bvalid, and there is exactly one AW handshake and one W handshake.
- Fixed priority with 3 masters all reading continuously: master 0 takes every grant, and masters 1 and 2 never see arready.
- Round-robin, same stimulus with `ARB_ROUND_ROBIN_EN`: grant sequence is 0,1,2,0,1,2, with one idle cycle between consecutive grants.
- Same master raises awvalid and arvalid together: write is served first, then the read in the next grant. No data is lost.
- Reset asserted mid-WR after AW done, before B: all outputs go to 0 immediately (async), and the state is IDLE after reset release. A new read then completes normally.

Source files
------------

// File: rtl/axi_lite_nto1_arbiter_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the AXI4-Lite N:1 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_e;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    // Index width for n requesters, never below one bit.
    function automatic int grant_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_nto1_arbiter_rr_pick.sv
// ============================================================================
// Module      : arb_rr_pick
// Description : Combinational picker: first requester at or above the pointer,
//               wrapping around; pointer ignored when rr_en is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int GW    = grant_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [GW-1:0]    ptr,
    input  logic             rr_en,
    output logic [NUM_M-1:0] win_oh,
    output logic [GW-1:0]    win_idx,
    output logic             win_valid
);

    int base;
    int j;

    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        base      = rr_en ? int'(ptr) : 0;
        j         = 0;
        for (int k = 0; k < NUM_M; k++) begin
            j = (base + k) % NUM_M;
            if (!win_valid && req[j]) begin
                win_valid = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = GW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_lite_nto1_arbiter.sv
// ============================================================================
// Module      : axi_lite_nto1_arbiter
// Description : N-master to 1-slave AXI4-Lite arbiter, one transaction in
//               flight. Define ARB_ROUND_ROBIN_EN for round-robin grant,
//               otherwise fixed priority (master 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_nto1_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int GW   = grant_width(NUM_M)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [NUM_M-1:0]      m_arvalid,
    output logic [NUM_M-1:0]      m_arready,
    input  logic [NUM_M*AW-1:0]   m_araddr,
    output logic [NUM_M-1:0]      m_rvalid,
    input  logic [NUM_M-1:0]      m_rready,
    output logic [NUM_M*DW-1:0]   m_rdata,
    output logic [NUM_M*2-1:0]    m_rresp,

    input  logic [NUM_M-1:0]      m_awvalid,
    output logic [NUM_M-1:0]      m_awready,
    input  logic [NUM_M*AW-1:0]   m_awaddr,
    input  logic [NUM_M-1:0]      m_wvalid,
    output logic [NUM_M-1:0]      m_wready,
    input  logic [NUM_M*DW-1:0]   m_wdata,
    input  logic [NUM_M*DW/8-1:0] m_wstrb,
    output logic [NUM_M-1:0]      m_bvalid,
    input  logic [NUM_M-1:0]      m_bready,
    output logic [NUM_M*2-1:0]    m_bresp,

    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [AW-1:0]         mem_araddr,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DW-1:0]         mem_rdata,
    input  logic [1:0]            mem_rresp,

    output logic                  mem_awvalid,
    input  logic                  mem_awready,
    output logic [AW-1:0]         mem_awaddr,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [DW-1:0]         mem_wdata,
    output logic [DW/8-1:0]       mem_wstrb,
    input  logic                  mem_bvalid,
    output logic                  mem_bready,
    input  logic [1:0]            mem_bresp,

    output logic [GW-1:0]         grant,
    output logic                  busy
);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            ar_done_q, ar_done_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] win_oh;
    logic [GW-1:0]    win_idx;
    logic             win_valid;
    logic             win_is_wr;
    logic [GW-1:0]    pick_ptr;
    logic             pick_rr;
    logic             rd_done;
    logic             wr_done;
    logic             wr_both_done;
    int               gi;

    assign req       = m_arvalid | m_awvalid;
    assign win_is_wr = |(win_oh & m_awvalid);

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;

    assign pick_ptr = rr_ptr_q;
    assign pick_rr  = 1'b1;

    // Pointer moves just past the owner when its transaction retires.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rd_done || wr_done) begin
            rr_ptr_d = (grant_q == GW'(NUM_M - 1)) ? '0 : grant_q + GW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign pick_ptr = '0;
    assign pick_rr  = 1'b0;
`endif

    arb_rr_pick #(
        .NUM_M (NUM_M),
        .GW    (GW)
    ) u_pick (
        .req       (req),
        .ptr       (pick_ptr),
        .rr_en     (pick_rr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign wr_both_done = aw_done_q & w_done_q;
    assign rd_done      = (state_q == RD) & mem_rvalid & mem_rready;
    assign wr_done      = (state_q == WR) & mem_bvalid & mem_bready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (win_valid) begin
                    grant_d = win_idx;
                    state_d = win_is_wr ? WR : RD;
                end
            end
            RD: begin
                if (mem_arvalid && mem_arready) ar_done_d = 1'b1;
                if (rd_done) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR: begin
                if (mem_awvalid && mem_awready) aw_done_d = 1'b1;
                if (mem_wvalid && mem_wready)   w_done_d  = 1'b1;
                if (wr_done) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Only the owner's channels are connected; everything else reads as zero.
    always_comb begin
        gi          = int'(grant_q);
        m_arready   = '0;
        m_rvalid    = '0;
        m_rdata     = '0;
        m_rresp     = '0;
        m_awready   = '0;
        m_wready    = '0;
        m_bvalid    = '0;
        m_bresp     = '0;
        mem_arvalid = 1'b0;
        mem_araddr  = '0;
        mem_rready  = 1'b0;
        mem_awvalid = 1'b0;
        mem_awaddr  = '0;
        mem_wvalid  = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_bready  = 1'b0;
        case (state_q)
            RD: begin
                mem_arvalid          = m_arvalid[grant_q] & ~ar_done_q;
                mem_araddr           = m_araddr[gi*AW +: AW];
                m_arready[grant_q]   = mem_arready & ~ar_done_q;
                mem_rready           = m_rready[grant_q];
                m_rvalid[grant_q]    = mem_rvalid;
                m_rdata[gi*DW +: DW] = mem_rdata;
                m_rresp[gi*2 +: 2]   = mem_rresp;
            end
            WR: begin
                mem_awvalid        = m_awvalid[grant_q] & ~aw_done_q;
                mem_awaddr         = m_awaddr[gi*AW +: AW];
                m_awready[grant_q] = mem_awready & ~aw_done_q;
                mem_wvalid         = m_wvalid[grant_q] & ~w_done_q;
                mem_wdata          = m_wdata[gi*DW +: DW];
                mem_wstrb          = m_wstrb[gi*(DW/8) +: (DW/8)];
                m_wready[grant_q]  = mem_wready & ~w_done_q;
                // A response is only meaningful once both AW and W have landed.
                mem_bready         = m_bready[grant_q] & wr_both_done;
                m_bvalid[grant_q]  = mem_bvalid & wr_both_done;
                m_bresp[gi*2 +: 2] = mem_bresp;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_nto1_arbiter.sv
// ============================================================================
// Module      : tb_axi_lite_nto1_arbiter
// Description : Directed self-checking bench for axi_lite_nto1_arbiter (3 masters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_nto1_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic [NM-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [NM*AW-1:0]   m_araddr, m_awaddr;
    logic [NM*DW-1:0]   m_rdata, m_wdata;
    logic [NM*DW/8-1:0] m_wstrb;
    logic [NM*2-1:0]    m_rresp, m_bresp;

    logic          mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic          mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
    logic [AW-1:0] mem_araddr, mem_awaddr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic [1:0]    mem_rresp, mem_bresp;
    logic [1:0]    grant;
    logic          busy;

    int n_pass = 0;
    int n_tot  = 0;
    int aw_hs  = 0;
    int w_hs   = 0;

    axi_lite_nto1_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && mem_awvalid && mem_awready) aw_hs <= aw_hs + 1;
        if (!rst && mem_wvalid && mem_wready)   w_hs  <= w_hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_inputs;
        m_arvalid = '0; m_araddr = '0; m_rready = '0;
        m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = '0;
    endtask

    initial begin
        int e;
        logic [2:0] oh;

        rst = 1'b1;
        clear_inputs();

        // Reset state: requests and slave readiness must not leak through.
        m_arvalid = 3'b111; mem_arready = 1'b1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_m_arready", m_arready, 0);
        chk("rst_mem_arvalid", mem_arvalid, 0);
        chk("rst_mem_awvalid", mem_awvalid, 0);
        clear_inputs();
        rst = 1'b0;
        tick();

        // Three masters reading back to back; slave answers AR and R together.
        m_arvalid = 3'b111; m_rready = 3'b111;
        mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        chk("arb_cycle_mem_arvalid", mem_arvalid, 0);
        for (int i = 0; i < 6; i++) begin
            e  = RR ? (i % 3) : 0;
            oh = 3'b001 << e;
            tick();
            chk("prio_busy", busy, 1);
            chk("prio_grant", grant, e);
            chk("prio_arready", m_arready, oh);
            chk("prio_rvalid", m_rvalid, oh);
            tick();
            chk("prio_bubble", busy, 0);
            if (i == 5) clear_inputs();
        end
        tick();
        chk("prio_idle_end", busy, 0);

        // Single read by master 1 with a 3-cycle slave latency.
        m_arvalid[1] = 1'b1; m_araddr[63:32] = 32'h8000_0010; m_rready[1] = 1'b1;
        tick();
        chk("rd_grant", grant, 1);
        chk("rd_mem_arvalid", mem_arvalid, 1);
        chk("rd_mem_araddr", mem_araddr, 32'h8000_0010);
        mem_arready = 1'b1;
        #1;
        chk("rd_m_arready", m_arready, 3'b010);
        tick();
        m_arvalid[1] = 1'b0; mem_arready = 1'b0;
        #1;
        chk("rd_ar_masked", mem_arvalid, 0);
        tick(); tick();
        chk("rd_wait_busy", busy, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'b00;
        #1;
        chk("rd_m_rvalid", m_rvalid, 3'b010);
        chk("rd_m0_rvalid", m_rvalid[0], 0);
        chk("rd_m1_rdata", m_rdata[63:32], 32'hDEAD_BEEF);
        chk("rd_m0_rdata", m_rdata[31:0], 0);
        chk("rd_mem_rready", mem_rready, 1);
        tick();
        mem_rvalid = 1'b0; m_rready = '0;
        chk("rd_busy_after", busy, 0);

        // Write by master 0: slave takes W two cycles before AW.
        m_awvalid[0] = 1'b1; m_awaddr[31:0] = 32'h1000_0004;
        m_wvalid[0] = 1'b1; m_wdata[31:0] = 32'h1234_5678; m_wstrb[3:0] = 4'hF;
        m_bready[0] = 1'b1;
        tick();
        chk("wr_grant", grant, 0);
        chk("wr_mem_awvalid", mem_awvalid, 1);
        chk("wr_mem_wvalid", mem_wvalid, 1);
        chk("wr_mem_awaddr", mem_awaddr, 32'h1000_0004);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("wr_mem_wstrb", mem_wstrb, 4'hF);
        mem_wready = 1'b1;
        #1;
        chk("wr_m_wready", m_wready, 3'b001);
        chk("wr_m_awready", m_awready, 0);
        tick();
        m_wvalid[0] = 1'b0; mem_wready = 1'b0;
        #1;
        chk("wr_w_dropped", mem_wvalid, 0);
        chk("wr_aw_held", mem_awvalid, 1);
        tick();
        mem_awready = 1'b1;
        #1;
        chk("wr_m_awready2", m_awready, 3'b001);
        tick();
        m_awvalid[0] = 1'b0; mem_awready = 1'b0;
        #1;
        chk("wr_aw_dropped", mem_awvalid, 0);
        chk("wr_bvalid_pre", m_bvalid, 0);
        mem_bvalid = 1'b1; mem_bresp = 2'b00;
        #1;
        chk("wr_m_bvalid", m_bvalid, 3'b001);
        chk("wr_mem_bready", mem_bready, 1);
        chk("wr_m_bresp", m_bresp, 0);
        tick();
        mem_bvalid = 1'b0; m_bready = '0;
        chk("wr_busy_after", busy, 0);
        chk("wr_aw_hs", aw_hs, 1);
        chk("wr_w_hs", w_hs, 1);

        // Master 2 issues write and read together: write goes first.
        m_awvalid[2] = 1'b1; m_awaddr[95:64] = 32'h3000_0000;
        m_wvalid[2] = 1'b1; m_wdata[95:64] = 32'hA5A5_5A5A; m_wstrb[11:8] = 4'h3;
        m_arvalid[2] = 1'b1; m_araddr[95:64] = 32'h3000_0040;
        m_bready[2] = 1'b1; m_rready[2] = 1'b1;
        tick();
        chk("both_grant", grant, 2);
        chk("both_wr_first", mem_awvalid, 1);
        chk("both_no_ar", mem_arvalid, 0);
        chk("both_wstrb", mem_wstrb, 4'h3);
        mem_awready = 1'b1; mem_wready = 1'b1; mem_arready = 1'b1;
        #1;
        chk("both_awready", m_awready, 3'b100);
        chk("both_arready_blocked", m_arready, 0);
        tick();
        m_awvalid[2] = 1'b0; m_wvalid[2] = 1'b0;
        mem_awready = 1'b0; mem_wready = 1'b0; mem_arready = 1'b0;
        mem_bvalid = 1'b1; mem_bresp = 2'b10;
        #1;
        chk("both_m_bvalid", m_bvalid, 3'b100);
        chk("both_m_bresp", m_bresp[5:4], 2'b10);
        tick();
        mem_bvalid = 1'b0;
        chk("both_bubble", busy, 0);
        tick();
        chk("both_rd_grant", grant, 2);
        chk("both_rd_arvalid", mem_arvalid, 1);
        chk("both_rd_araddr", mem_araddr, 32'h3000_0040);
        mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_rresp = 2'b10;
        #1;
        chk("both_rd_rdata", m_rdata[95:64], 32'hCAFE_F00D);
        chk("both_rd_rresp", m_rresp[5:4], 2'b10);
        tick();
        clear_inputs();
        #1;
        chk("both_rd_done", busy, 0);

        // Reset mid-write after AW completed, before B.
        m_awvalid[1] = 1'b1; m_awaddr[63:32] = 32'h4000_0000;
        m_wvalid[1] = 1'b1; m_wdata[63:32] = 32'h0000_0001; m_wstrb[7:4] = 4'hF;
        m_bready[1] = 1'b1;
        tick();
        mem_awready = 1'b1;
        tick();
        m_awvalid[1] = 1'b0; mem_awready = 1'b0; mem_wready = 1'b1;
        #1;
        chk("mid_aw_done", mem_awvalid, 0);
        chk("mid_w_pending", mem_wvalid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wvalid", mem_wvalid, 0);
        chk("mid_rst_wready", m_wready, 0);
        chk("mid_rst_grant", grant, 0);
        tick();
        clear_inputs();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", busy, 0);
        m_arvalid[0] = 1'b1; m_araddr[31:0] = 32'h2000_0000; m_rready[0] = 1'b1;
        tick();
        chk("post_rd_grant", grant, 0);
        chk("post_rd_araddr", mem_araddr, 32'h2000_0000);
        mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("post_rd_rdata", m_rdata[31:0], 32'h0BAD_F00D);
        chk("post_rd_rvalid", m_rvalid, 3'b001);
        tick();
        clear_inputs();
        #1;
        chk("post_rd_done", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
